// File: rtl/ecc_log_pkg.sv
// ecc_log_pkg: shared widths, log entry type and saturating-increment helper for the ECC error logger.
// Rev 1.0
`default_nettype none

package ecc_log_pkg;

    localparam int ECC_ADDR_W = 14;
    localparam int ECC_DATA_W = 64;

    typedef struct packed {
        logic [ECC_ADDR_W-1:0] addr;
        logic [ECC_DATA_W-1:0] data;
        logic                  db;
    } ecc_log_entry_t;

    // Increments v but holds at 2**w-1; callers pass counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        return ({1'b0, v} == lim) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_log_fifo.sv
// ecc_log_fifo: first-word-fall-through FIFO of log entries with MSB-extended pointers.
// Rev 1.0
`default_nettype none

module ecc_log_fifo
    import ecc_log_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type ENTRY_T = ecc_log_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  ENTRY_T                   wdata,
    output ENTRY_T                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    ENTRY_T      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    // Storage is not reset, so an empty FIFO presents zeros instead of stale entries.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ecc_err_logger.sv
// ecc_err_logger: queues ECC error reports, keeps saturating SB/DB counters and sticky overflow.
// Rev 1.0 -- define ECC_LOG_DEDUP_EN to suppress back-to-back repeats of the last pushed report.
`default_nettype none

module ecc_err_logger
    import ecc_log_pkg::*;
#(
    parameter int ADDR_W = ECC_ADDR_W,
    parameter int DATA_W = ECC_DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     err_valid,
    input  logic [ADDR_W-1:0]        err_addr,
    input  logic [DATA_W-1:0]        err_data,
    input  logic                     err_db,
    input  logic                     clr,
    output logic                     log_valid,
    input  logic                     log_ready,
    output logic [ADDR_W-1:0]        log_addr,
    output logic [DATA_W-1:0]        log_data,
    output logic                     log_db,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         sb_count,
    output logic [CNT_W-1:0]         db_count,
    output logic                     overflow
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              db;
    } entry_t;

    entry_t wdata;
    entry_t rdata;
    logic   full;
    logic   empty;
    logic   candidate;
    logic   push;
    logic   pop;
    logic   drop;

    assign wdata = '{addr: err_addr, data: err_data, db: err_db};

`ifdef ECC_LOG_DEDUP_EN
    logic [ADDR_W-1:0] tag_addr;
    logic              tag_db;
    logic              tag_valid;

    // A pending clr invalidates the tag for this cycle's comparison as well.
    assign candidate = err_valid &&
                       !(tag_valid && !clr && (tag_addr == err_addr) && (tag_db == err_db));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_addr  <= '0;
            tag_db    <= 1'b0;
            tag_valid <= 1'b0;
        end else if (push) begin
            tag_addr  <= err_addr;
            tag_db    <= err_db;
            tag_valid <= 1'b1;
        end else if (clr) begin
            tag_valid <= 1'b0;
        end
    end
`else
    assign candidate = err_valid;
`endif

    assign pop  = log_valid && log_ready;
    assign push = candidate && (!full || pop);
    assign drop = candidate && full && !pop;

    ecc_log_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign log_valid = !empty;
    assign log_addr  = rdata.addr;
    assign log_data  = rdata.data;
    assign log_db    = rdata.db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_count <= '0;
            db_count <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            sb_count <= (err_valid && !err_db) ? CNT_W'(1) : '0;
            db_count <= (err_valid &&  err_db) ? CNT_W'(1) : '0;
            overflow <= drop;
        end else begin
            if (err_valid && !err_db) sb_count <= CNT_W'(sat_inc(32'(sb_count), CNT_W));
            if (err_valid &&  err_db) db_count <= CNT_W'(sat_inc(32'(db_count), CNT_W));
            if (drop)                 overflow <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ecc_err_logger.sv
// tb_ecc_err_logger: table vectors, directed corner sequences and random traffic against a queue model.
// Rev 1.0
`default_nettype none

module tb_ecc_err_logger;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              err_valid = 1'b0;
    logic [ADDR_W-1:0] err_addr = '0;
    logic [DATA_W-1:0] err_data = '0;
    logic              err_db = 1'b0;
    logic              clr = 1'b0;
    logic              log_valid;
    logic              log_ready = 1'b0;
    logic [ADDR_W-1:0] log_addr;
    logic [DATA_W-1:0] log_data;
    logic              log_db;
    logic [3:0]        level;
    logic [CNT_W-1:0]  sb_count;
    logic [CNT_W-1:0]  db_count;
    logic              overflow;

    ecc_err_logger #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_data  (err_data),
        .err_db    (err_db),
        .clr       (clr),
        .log_valid (log_valid),
        .log_ready (log_ready),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_db    (log_db),
        .level     (level),
        .sb_count  (sb_count),
        .db_count  (db_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              db;
    } ent_t;

    typedef struct {
        logic              ev;
        logic [ADDR_W-1:0] addr;
        logic              db;
        logic              rdy;
        logic              c;
        int                lvl;
        logic [ADDR_W-1:0] eaddr;
        int                esb;
        int                edb;
        logic              eov;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ent_t m_q[$];
    int   m_sb = 0;
    int   m_db = 0;
    logic m_ov = 1'b0;
    logic              m_tagv = 1'b0;
    logic [ADDR_W-1:0] m_tag_addr = '0;
    logic              m_tag_db = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sb = 0;
        m_db = 0;
        m_ov = 1'b0;
        m_tagv = 1'b0;
    endtask

    // Applies one clock's worth of traffic to the reference queue and counters.
    task automatic model_step(input logic ev, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic db, input logic rdy, input logic c);
        logic pop_now, cand, was_full, accepted, dropped;
        pop_now  = (m_q.size() > 0) && rdy;
        was_full = (m_q.size() == DEPTH);
        cand     = ev;
`ifdef ECC_LOG_DEDUP_EN
        if (ev && m_tagv && !c && a == m_tag_addr && db == m_tag_db) cand = 1'b0;
`endif
        accepted = cand && (!was_full || pop_now);
        dropped  = cand && was_full && !pop_now;
        if (pop_now) void'(m_q.pop_front());
        if (accepted) m_q.push_back('{addr: a, data: d, db: db});
        if (accepted) begin
            m_tagv = 1'b1;
            m_tag_addr = a;
            m_tag_db = db;
        end else if (c) begin
            m_tagv = 1'b0;
        end
        if (c) begin
            m_sb = (ev && !db) ? 1 : 0;
            m_db = (ev &&  db) ? 1 : 0;
            m_ov = dropped;
        end else begin
            if (ev && !db && m_sb < CNT_MAX) m_sb++;
            if (ev &&  db && m_db < CNT_MAX) m_db++;
            m_ov = m_ov | dropped;
        end
    endtask

    task automatic cyc(input logic ev, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic db, input logic rdy, input logic c);
        @(negedge clk);
        err_valid = ev;
        err_addr  = a;
        err_data  = d;
        err_db    = db;
        log_ready = rdy;
        clr       = c;
        model_step(ev, a, d, db, rdy, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".log_valid"}, 64'(log_valid), 64'(m_q.size() != 0));
        chk({tag, ".level"}, 64'(level), 64'(m_q.size()));
        if (m_q.size() != 0) begin
            chk({tag, ".log_addr"}, 64'(log_addr), 64'(m_q[0].addr));
            chk({tag, ".log_data"}, log_data, m_q[0].data);
            chk({tag, ".log_db"}, 64'(log_db), 64'(m_q[0].db));
        end
        chk({tag, ".sb_count"}, 64'(sb_count), 64'(m_sb));
        chk({tag, ".db_count"}, 64'(db_count), 64'(m_db));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        logic [DATA_W-1:0] rd;

        tbl[0]  = '{1'b1, 14'h010, 1'b0, 1'b0, 1'b0, 1, 14'h010, 1, 0, 1'b0};
        tbl[1]  = '{1'b1, 14'h020, 1'b0, 1'b0, 1'b0, 2, 14'h010, 2, 0, 1'b0};
        tbl[2]  = '{1'b1, 14'h030, 1'b0, 1'b0, 1'b0, 3, 14'h010, 3, 0, 1'b0};
        tbl[3]  = '{1'b1, 14'h040, 1'b0, 1'b0, 1'b0, 4, 14'h010, 4, 0, 1'b0};
        tbl[4]  = '{1'b1, 14'h050, 1'b0, 1'b0, 1'b0, 5, 14'h010, 5, 0, 1'b0};
        tbl[5]  = '{1'b1, 14'h060, 1'b0, 1'b0, 1'b0, 6, 14'h010, 6, 0, 1'b0};
        tbl[6]  = '{1'b1, 14'h070, 1'b0, 1'b0, 1'b0, 7, 14'h010, 7, 0, 1'b0};
        tbl[7]  = '{1'b1, 14'h080, 1'b0, 1'b0, 1'b0, 8, 14'h010, 8, 0, 1'b0};
        tbl[8]  = '{1'b1, 14'h090, 1'b1, 1'b0, 1'b0, 8, 14'h010, 8, 1, 1'b1};
        tbl[9]  = '{1'b1, 14'h0A0, 1'b0, 1'b1, 1'b0, 8, 14'h020, 9, 1, 1'b1};
        tbl[10] = '{1'b0, 14'h000, 1'b0, 1'b0, 1'b1, 8, 14'h020, 0, 0, 1'b0};
        tbl[11] = '{1'b1, 14'h0B0, 1'b0, 1'b0, 1'b1, 8, 14'h020, 1, 0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst.log_valid", 64'(log_valid), 64'd0);
        chk("rst.level", 64'(level), 64'd0);
        chk("rst.log_addr", 64'(log_addr), 64'd0);
        chk("rst.log_data", log_data, 64'd0);
        chk("rst.log_db", 64'(log_db), 64'd0);
        chk("rst.counts", 64'({sb_count, db_count}), 64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].ev, tbl[i].addr, {50'h0, tbl[i].addr} ^ 64'hA5A5_0000_0000_0000,
                tbl[i].db, tbl[i].rdy, tbl[i].c);
            chk($sformatf("vec%0d.level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("vec%0d.log_addr", i), 64'(log_addr), 64'(tbl[i].eaddr));
            chk($sformatf("vec%0d.sb", i), 64'(sb_count), 64'(tbl[i].esb));
            chk($sformatf("vec%0d.db", i), 64'(db_count), 64'(tbl[i].edb));
            chk($sformatf("vec%0d.ov", i), 64'(overflow), 64'(tbl[i].eov));
            chk($sformatf("vec%0d.log_data", i), log_data, m_q[0].data);
        end

        // Drain: tail must hold 0x0A0 as the last entry (0x0B0 was dropped).
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            check_model($sformatf("drain%0d", i));
        end
        chk("drain.empty", 64'(log_valid), 64'd0);

        // Saturation: 17 SB reports with the consumer draining.
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) cyc(1'b1, 14'(i), 64'(i), 1'b0, 1'b1, 1'b0);
        chk("sat.sb", 64'(sb_count), 64'd15);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("sat.clr", 64'(sb_count), 64'd0);
        cyc(1'b1, 14'h3, 64'h3, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 14'h5, 64'h5, 1'b0, 1'b1, 1'b1);
        chk("sat.clr_ev", 64'(sb_count), 64'd1);
        check_model("sat");

        // Async reset with 5 entries while the consumer is popping.
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 14'(16'h100 + i), 64'(i), 1'(i & 1), 1'b0, 1'b0);
        chk("arst.pre_level", 64'(level), 64'd5);
        @(negedge clk);
        err_valid = 1'b0;
        log_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.log_valid", 64'(log_valid), 64'd0);
        chk("arst.level", 64'(level), 64'd0);
        chk("arst.counts", 64'({sb_count, db_count}), 64'd0);
        chk("arst.overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        log_ready = 1'b0;

`ifdef ECC_LOG_DEDUP_EN
        cyc(1'b1, 14'h1234, 64'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h1234, 64'h2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 14'h1234, 64'h3, 1'b1, 1'b0, 1'b0);
        chk("dedup.level", 64'(level), 64'd2);
        chk("dedup.sb", 64'(sb_count), 64'd2);
        chk("dedup.db", 64'(db_count), 64'd1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 14'h1234, 64'h4, 1'b1, 1'b0, 1'b0);
        chk("dedup.after_clr", 64'(level), 64'd3);
`endif

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom};
            cyc(($urandom_range(0, 9) < 6), 14'(16'h0200 + $urandom_range(0, 5)), rd,
                ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 3 : 7)),
                ($urandom_range(0, 49) == 0));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
